x7seg_scan: RTL

- Time-multiplexed scan controller for a NDIG-digit common-anode 7-segment display.
- Sits directly upstream of the hex7seg decoder. It drives the decoder's 4-bit x input with the nibble of the currently selected digit and drives the active-low anode lines and the decimal point.
- Display contents are double-buffered: new values are committed only at a frame boundary, so a frame never mixes old and new digits.

---
 rtl/x7seg_scan_if.sv | 28 ++
 rtl/x7seg_scan.sv | 138 +++++++++++++
 2 files changed

// File: rtl/x7seg_scan_if.sv
// x7seg_scan_if: host/display bundle for the 7-segment scan controller.
//   load/value/dp_in/en_in : pending-buffer write (one-cycle strobe + data)
//   lzb                    : live leading-zero blanking enable
//   digit/an/dp            : registered scan outputs (digit feeds hex7seg x)
//   frame_sync             : one-cycle pulse on each frame-boundary commit
// master = host side (drives load/data), slave = scan controller.
interface x7seg_scan_if #(
    parameter int NDIG = 4
);
    logic              load;
    logic [4*NDIG-1:0] value;
    logic [NDIG-1:0]   dp_in;
    logic [NDIG-1:0]   en_in;
    logic              lzb;
    logic [3:0]        digit;
    logic [NDIG-1:0]   an;
    logic              dp;
    logic              frame_sync;

    modport master (
        output load, value, dp_in, en_in, lzb,
        input  digit, an, dp, frame_sync
    );
    modport slave (
        input  load, value, dp_in, en_in, lzb,
        output digit, an, dp, frame_sync
    );
endinterface

// File: rtl/x7seg_scan.sv
// x7seg_scan: time-multiplexed scan controller for an NDIG-digit
// common-anode 7-segment display, double-buffered at frame boundaries.
//   clk   : system clock
//   clr_n : asynchronous active-low reset
//   bus   : x7seg_scan_if.slave (load/value/dp_in/en_in/lzb in,
//           digit/an/dp/frame_sync out)
// The scan advances one digit every 2^DIV_W clocks; GUARD dark cycles
// follow each advance to suppress ghosting. Outputs are registered from
// the next-state index/active buffer so they move on the same edge as idx.
module x7seg_scan #(
    parameter int NDIG  = 4,
    parameter int DIV_W = 17,
    parameter int GUARD = 2
) (
    input  logic            clk,
    input  logic            clr_n,
    x7seg_scan_if.slave     bus
);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [DIV_W-1:0] GUARD_V = DIV_W'(GUARD);
    localparam logic [IW-1:0]    LAST_V  = IW'(NDIG - 1);
    localparam logic [NDIG-1:0]  AN_ONE  = NDIG'(1);

    // prescaler / scan position
    logic [DIV_W-1:0]  cnt;
    logic [IW-1:0]     idx, idx_nxt;
    logic [DIV_W-1:0]  grd, grd_nxt;

    // active (displayed) and pending (next frame) buffers
    logic [4*NDIG-1:0] act_val, act_val_nxt, pnd_val;
    logic [NDIG-1:0]   act_dp,  act_dp_nxt,  pnd_dp;
    logic [NDIG-1:0]   act_en,  act_en_nxt,  pnd_en;
    logic              pnd;

    // registered outputs and their next values
    logic [3:0]        digit_q, digit_nxt;
    logic [NDIG-1:0]   an_q,    an_nxt;
    logic              dp_q,    dp_nxt;
    logic              fs_q;

    logic              tick, commit, vis;
    logic [NDIG-1:0]   hi_zero;   // nibble k and all above are zero
    logic [NDIG-1:0]   blank;     // digit k blanked by lzb

    assign tick   = &cnt;
    assign commit = tick && (idx == LAST_V);

    // ---------------- next-state ----------------
    always_comb begin
        idx_nxt     = idx;
        grd_nxt     = grd;
        act_val_nxt = act_val;
        act_dp_nxt  = act_dp;
        act_en_nxt  = act_en;
        if (tick) begin
            idx_nxt = (idx == LAST_V) ? '0 : idx + 1'b1;
            grd_nxt = GUARD_V;
        end else if (grd != '0) begin
            grd_nxt = grd - 1'b1;
        end
        // commit uses pending as it stood before this edge, so a load on
        // the same edge is kept for the following frame
        if (commit && pnd) begin
            act_val_nxt = pnd_val;
            act_dp_nxt  = pnd_dp;
            act_en_nxt  = pnd_en;
        end
    end

    // Leading-zero detection over the buffer that will be active after
    // this edge; digit 0 is exempt.
    assign hi_zero[NDIG-1] = (act_val_nxt[4*(NDIG-1) +: 4] == 4'h0);
    genvar k;
    generate
        for (k = NDIG - 2; k >= 0; k--) begin : g_hz
            assign hi_zero[k] = (act_val_nxt[4*k +: 4] == 4'h0) && hi_zero[k+1];
        end
        for (k = 0; k < NDIG; k++) begin : g_blk
            if (k == 0) begin : g_d0
                assign blank[k] = 1'b0;
            end else begin : g_dk
                assign blank[k] = bus.lzb && hi_zero[k];
            end
        end
    endgenerate

    // ---------------- output next values ----------------
    always_comb begin
        vis       = act_en_nxt[idx_nxt] && (grd_nxt == '0) && !blank[idx_nxt];
        digit_nxt = act_val_nxt[{idx_nxt, 2'b00} +: 4];
        dp_nxt    = vis && act_dp_nxt[idx_nxt];
        an_nxt    = vis ? ~(AN_ONE << idx_nxt) : '1;
    end

    // ---------------- state ----------------
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt     <= '0;
            idx     <= '0;
            grd     <= '0;
            act_val <= '0;
            act_dp  <= '0;
            act_en  <= '0;
            pnd_val <= '0;
            pnd_dp  <= '0;
            pnd_en  <= '0;
            pnd     <= 1'b0;
            digit_q <= '0;
            an_q    <= '1;
            dp_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            cnt     <= cnt + 1'b1;
            idx     <= idx_nxt;
            grd     <= grd_nxt;
            act_val <= act_val_nxt;
            act_dp  <= act_dp_nxt;
            act_en  <= act_en_nxt;
            if (bus.load) begin
                pnd_val <= bus.value;
                pnd_dp  <= bus.dp_in;
                pnd_en  <= bus.en_in;
                pnd     <= 1'b1;
            end else if (commit) begin
                pnd     <= 1'b0;
            end
            digit_q <= digit_nxt;
            an_q    <= an_nxt;
            dp_q    <= dp_nxt;
            fs_q    <= commit;
        end
    end

    assign bus.digit      = digit_q;
    assign bus.an         = an_q;
    assign bus.dp         = dp_q;
    assign bus.frame_sync = fs_q;
endmodule
